// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t          : fetch FSM states (IDLE, WAIT, DRAIN)
//   NOP              : canonical no-op encoding (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   PC_INC           : byte distance between sequential instruction words
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the datapath.
//   imem_req / imem_addr       : read request toward instruction memory
//   imem_ack / imem_rdata      : read completion and returned word
//   instr_valid / instr /
//   instr_pc / instr_ready     : instruction stream toward the datapath
// master: the fetch unit side.  slave: memory + datapath side.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of DEPTH entries, each DATA_W bits wide.
//   clk, reset : clock and synchronous active-high reset
//   flush      : empties the FIFO; overrides push and pop in the same cycle
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   push_data  : entry to write
//   head_data  : entry at the head (registered storage, no bypass)
//   count      : number of occupied entries, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is never reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    push_when_full : assert property (@(posedge clk) disable iff (reset || flush)
        !(push && !pop && (count == DEPTH_C)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time word reads to
// instruction memory, buffers returned words in a prefetch FIFO and hands
// {instr, instr_pc} to the datapath with valid/ready.
//   clk, reset  : clock and synchronous active-high reset
//   bus         : master side of instr_fetch_unit_if (imem req/ack and
//                 instruction stream)
//   redirect    : one-cycle pulse; flush and restart fetch at redirect_pc
//   redirect_pc : new fetch address, low two bits ignored
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                      clk,
    input  logic                      reset,
    instr_fetch_unit_if.master        bus,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    state_t        state;
    logic [31:0]   fpc;
    logic [31:0]   target_pc;
    logic [31:0]   next_pc;
    logic          ack;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          unused_pc_bits;

    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign next_pc        = fpc + PC_INC;

    // The ack only counts while a request is actually on the bus, so a
    // late ack after reset or before issue is ignored.
    assign ack  = bus.imem_req & bus.imem_ack;
    assign push = (state == WAIT) & ack & ~redirect;
    assign pop  = bus.instr_valid & bus.instr_ready & ~redirect;

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .pop       (pop),
        .push_data ({fpc, bus.imem_rdata}),
        .head_data (head),
        .count     (count)
    );

    // Outputs read back as zero when the FIFO is empty, which also covers
    // the never-reset storage right after reset.
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? head[31:0]  : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? head[63:32] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            fpc           <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fpc <= target_pc;
                    end else if (count < DEPTH_C) begin
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= fpc;
                        state         <= WAIT;
                    end
                end
                WAIT, DRAIN: begin
                    if (redirect) begin
                        fpc <= target_pc;
                        if (ack) begin
                            // Acked word is dropped; restart immediately.
                            bus.imem_addr <= target_pc;
                            state         <= WAIT;
                        end else begin
                            // Request cannot be withdrawn; hold it and
                            // discard its data when it completes.
                            state <= DRAIN;
                        end
                    end else if (ack) begin
                        if (state == DRAIN) begin
                            bus.imem_addr <= fpc;
                            state         <= WAIT;
                        end else begin
                            fpc <= next_pc;
                            // Registered count plus this push must leave room.
                            if (count < LAST_C) begin
                                bus.imem_addr <= next_pc;
                            end else begin
                                bus.imem_req <= 1'b0;
                                state        <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        reset_b;
    logic        redirect;
    logic [31:0] redirect_pc;

    int   n_chk = 0;
    int   n_err = 0;
    int   wait_a = 0;
    int   wait_b = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    logic busy_a = 1'b0;
    logic busy_b = 1'b0;

    logic [31:0] wrap_seq [4];

    instr_fetch_unit_if bus_a ();
    instr_fetch_unit_if bus_b ();

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .reset       (reset_a),
        .bus         (bus_a),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clk         (clk),
        .reset       (reset_b),
        .bus         (bus_b),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: ack after wt extra cycles of a continuously held request.
    task automatic mem_step(input logic req, input int wt, inout int cnt,
                            inout logic busy, output logic ack);
        if (req) begin
            if (busy) cnt++;
            else      cnt = 0;
            ack  = (cnt >= wt);
            busy = !ack;
        end else begin
            cnt  = 0;
            busy = 1'b0;
            ack  = 1'b0;
        end
    endtask

    task automatic tick();
        logic ack_t;
        @(posedge clk);
        #1;
        mem_step(bus_a.imem_req, wait_a, cnt_a, busy_a, ack_t);
        bus_a.imem_ack   = ack_t;
        bus_a.imem_rdata = bus_a.imem_addr;
        mem_step(bus_b.imem_req, wait_b, cnt_b, busy_b, ack_t);
        bus_b.imem_ack   = ack_t;
        bus_b.imem_rdata = bus_b.imem_addr;
    endtask

    task automatic restart_a();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
    endtask

    initial begin
        wrap_seq[0] = 32'hFFFF_FFF8;
        wrap_seq[1] = 32'hFFFF_FFFC;
        wrap_seq[2] = 32'h0000_0000;
        wrap_seq[3] = 32'h0000_0004;

        reset_a           = 1'b1;
        reset_b           = 1'b1;
        redirect          = 1'b0;
        redirect_pc       = 32'h0;
        bus_a.imem_ack    = 1'b0;
        bus_a.imem_rdata  = 32'h0;
        bus_a.instr_ready = 1'b0;
        bus_b.imem_ack    = 1'b0;
        bus_b.imem_rdata  = 32'h0;
        bus_b.instr_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req",    bus_a.imem_req,    32'h0);
        check("rst_addr",   bus_a.imem_addr,   32'h0);
        check("rst_valid",  bus_a.instr_valid, 32'h0);
        check("rst_instr",  bus_a.instr,       32'h0);
        check("rst_pc",     bus_a.instr_pc,    32'h0);
        check("rstw_req",   bus_b.imem_req,    32'h0);
        check("rstw_addr",  bus_b.imem_addr,   32'hFFFF_FFF8);
        check("rstw_valid", bus_b.instr_valid, 32'h0);

        // Zero-wait memory, streaming one instruction per cycle
        wait_a = 0;
        bus_a.instr_ready = 1'b1;
        reset_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t1_req_%0d", k),  bus_a.imem_req,  32'h1);
            check($sformatf("t1_addr_%0d", k), bus_a.imem_addr, 32'(4 * (k - 1)));
            if (k == 1) begin
                check("t1_valid_1", bus_a.instr_valid, 32'h0);
            end else begin
                check($sformatf("t1_valid_%0d", k), bus_a.instr_valid, 32'h1);
                check($sformatf("t1_pc_%0d", k),    bus_a.instr_pc,    32'(4 * (k - 2)));
                check($sformatf("t1_instr_%0d", k), bus_a.instr,       32'(4 * (k - 2)));
            end
        end

        // Reset in the middle of an outstanding request
        reset_a = 1'b1;
        tick();
        check("midrst_req",   bus_a.imem_req,    32'h0);
        check("midrst_addr",  bus_a.imem_addr,   32'h0);
        check("midrst_valid", bus_a.instr_valid, 32'h0);
        reset_a = 1'b0;

        // Three-cycle memory latency
        wait_a = 2;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t2_req_%0d", k),  bus_a.imem_req,  32'h1);
            check($sformatf("t2_addr_%0d", k), bus_a.imem_addr, 32'(4 * ((k - 1) / 3)));
            if (k >= 4 && ((k - 1) % 3) == 0) begin
                check($sformatf("t2_valid_%0d", k), bus_a.instr_valid, 32'h1);
                check($sformatf("t2_pc_%0d", k),    bus_a.instr_pc,    32'(4 * ((k - 4) / 3)));
            end else begin
                check($sformatf("t2_valid_%0d", k), bus_a.instr_valid, 32'h0);
            end
        end

        // Back-pressure: FIFO fills to DEPTH then requests stop
        wait_a = 0;
        bus_a.instr_ready = 1'b0;
        restart_a();
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t3_req_%0d", k), bus_a.imem_req, (k <= 4) ? 32'h1 : 32'h0);
            if (k <= 4) check($sformatf("t3_addr_%0d", k), bus_a.imem_addr, 32'(4 * (k - 1)));
            if (k >= 5) begin
                check($sformatf("t3_valid_%0d", k), bus_a.instr_valid, 32'h1);
                check($sformatf("t3_pc_%0d", k),    bus_a.instr_pc,    32'h0);
            end
        end
        bus_a.instr_ready = 1'b1;
        for (int k = 11; k <= 15; k++) begin
            tick();
            check($sformatf("t3_valid_%0d", k), bus_a.instr_valid, 32'h1);
            check($sformatf("t3_pc_%0d", k),    bus_a.instr_pc,    32'(4 * (k - 10)));
            if (k == 11) check("t3_req_11", bus_a.imem_req, 32'h0);
            if (k == 12) begin
                check("t3_req_12",  bus_a.imem_req,  32'h1);
                check("t3_addr_12", bus_a.imem_addr, 32'h10);
            end
        end

        // Redirect while a slow request is pending: DRAIN
        wait_a = 2;
        restart_a();
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 15) redirect = 1'b0;
            if (k == 13 || k == 14 || k == 15) begin
                check($sformatf("t4_req_%0d", k),  bus_a.imem_req,  32'h1);
                check($sformatf("t4_addr_%0d", k), bus_a.imem_addr, 32'h10);
            end
            if (k == 14) begin
                check("t4_ack_14", bus_a.imem_ack, 32'h0);
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0103;
            end
            if (k >= 15 && k <= 18) check($sformatf("t4_valid_%0d", k), bus_a.instr_valid, 32'h0);
            if (k >= 16 && k <= 18) check($sformatf("t4_addr_%0d", k), bus_a.imem_addr, 32'h100);
            if (k == 19) begin
                check("t4_valid_19", bus_a.instr_valid, 32'h1);
                check("t4_pc_19",    bus_a.instr_pc,    32'h100);
                check("t4_instr_19", bus_a.instr,       32'h100);
            end
        end

        // Redirect coincident with ack and a pop
        wait_a = 0;
        restart_a();
        tick();
        tick();
        tick();
        check("t5_valid_3", bus_a.instr_valid, 32'h1);
        check("t5_pc_3",    bus_a.instr_pc,    32'h4);
        check("t5_addr_3",  bus_a.imem_addr,   32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("t5_valid_4", bus_a.instr_valid, 32'h0);
        check("t5_req_4",   bus_a.imem_req,    32'h1);
        check("t5_addr_4",  bus_a.imem_addr,   32'h200);
        tick();
        check("t5_valid_5", bus_a.instr_valid, 32'h1);
        check("t5_pc_5",    bus_a.instr_pc,    32'h200);
        check("t5_instr_5", bus_a.instr,       32'h200);
        check("t5_addr_5",  bus_a.imem_addr,   32'h204);

        // Address wrap from a high RESET_PC, then reset during WAIT
        reset_a = 1'b1;
        wait_b = 0;
        bus_b.instr_ready = 1'b1;
        reset_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t6_addr_%0d", k), bus_b.imem_addr, wrap_seq[k - 1]);
            if (k >= 2) begin
                check($sformatf("t6_valid_%0d", k), bus_b.instr_valid, 32'h1);
                check($sformatf("t6_pc_%0d", k),    bus_b.instr_pc,    wrap_seq[k - 2]);
            end
        end
        reset_b = 1'b1;
        tick();
        check("t6_rst_req",   bus_b.imem_req,    32'h0);
        check("t6_rst_addr",  bus_b.imem_addr,   32'hFFFF_FFF8);
        check("t6_rst_valid", bus_b.instr_valid, 32'h0);
        reset_b = 1'b0;
        tick();
        check("t6_re_req",  bus_b.imem_req,  32'h1);
        check("t6_re_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
        tick();
        check("t6_re_valid", bus_b.instr_valid, 32'h1);
        check("t6_re_pc",    bus_b.instr_pc,    32'hFFFF_FFF8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
